// File: rtl/serial_pkg.sv
// serial_pkg: shared types and sizing helpers for the serial transmitter and its receiver-side benches
package serial_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  localparam int N_DEF = 32;
  localparam int DIV_DEF = 1;
  function automatic int bit_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/serial_tx_bit_timer.sv
// bit_timer: counts DIV cycles per bit period while running and flags the last cycle of each period
module bit_timer #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  output logic tick
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == CW'(DIV - 1);
  // restart the period when idle or after the last cycle of a period
  always_comb cnt_d = (!run || tick) ? '0 : cnt_q + CW'(1);
  // divider register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/serial_tx.sv
// serial_tx: accepts an N-bit word on start/ready and shifts it out LSB-first with one strobe per bit
module serial_tx
  import serial_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int DIV = DIV_DEF
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [N-1:0] d,
  input  logic         start,
  output logic         ready,
  output logic         w,
  output logic         e,
  output logic         done
);
  localparam int CW = bit_cnt_w(N);
  state_e state_q, state_d;
  logic [N-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic tick, last, accept;
  bit_timer #(.DIV(DIV)) u_timer (
    .clk(clk),
    .resetn(resetn),
    .run(state_q == SHIFT),
    .tick(tick)
  );
  assign accept = (state_q == IDLE) & start;
  assign last = cnt_q == CW'(N - 1);
  // state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state_q <= IDLE;
    else state_q <= state_d;
  // next state: a word runs until the strobe of its final bit, then one DONE cycle
  always_comb
    state_d = accept ? SHIFT :
              (state_q == SHIFT && tick && last) ? DONE :
              (state_q == DONE) ? IDLE : state_q;
  // outputs decoded from registered state only
  always_comb begin
    ready = state_q == IDLE;
    e = tick & (state_q == SHIFT);
    done = state_q == DONE;
    w = (state_q == SHIFT) & sr_q[0];
  end
  // datapath next values: load on accept, shift and count on each strobe
  always_comb begin
    sr_d = accept ? d : e ? {1'b0, sr_q[N-1:1]} : sr_q;
    cnt_d = accept ? '0 : e ? cnt_q + CW'(1) : cnt_q;
  end
  // shift register and bit counter
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      sr_q <= '0;
      cnt_q <= '0;
    end else begin
      sr_q <= sr_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: cycle-timed scoreboard bench for serial_tx at three width/rate configurations
module tb_serial_tx;
  typedef struct {
    int cyc;
    logic w;
    logic e;
    logic dn;
    logic rdy;
    logic chk_rx;
    logic [31:0] rx;
  } exp_t;

  logic clk = 0;
  always #5 clk = ~clk;

  int nw[3] = '{8, 32, 8};
  int dv[3] = '{1, 4, 2};
  logic rstn[3];
  logic st[3];
  logic [31:0] dd[3];
  logic rdy[3], ww[3], ee[3], dn[3];
  logic [31:0] rx[3];
  exp_t sb[3][$];
  int cyc = 0;
  int total = 0;
  int bad = 0;

  serial_tx #(.N(8), .DIV(1)) dut_a (
    .clk(clk), .resetn(rstn[0]), .d(dd[0][7:0]), .start(st[0]),
    .ready(rdy[0]), .w(ww[0]), .e(ee[0]), .done(dn[0])
  );
  serial_tx #(.N(32), .DIV(4)) dut_b (
    .clk(clk), .resetn(rstn[1]), .d(dd[1]), .start(st[1]),
    .ready(rdy[1]), .w(ww[1]), .e(ee[1]), .done(dn[1])
  );
  serial_tx #(.N(8), .DIV(2)) dut_c (
    .clk(clk), .resetn(rstn[2]), .d(dd[2][7:0]), .start(st[2]),
    .ready(rdy[2]), .w(ww[2]), .e(ee[2]), .done(dn[2])
  );

  always @(posedge clk) cyc <= cyc + 1;

  // receiver model: shift right with w entering at bit N-1
  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (ee[i]) rx[i] <= (rx[i] >> 1) | (32'(ww[i]) << (nw[i] - 1));

  function automatic logic [31:0] mask(input int n);
    return (n >= 32) ? 32'hFFFF_FFFF : (32'd1 << n) - 32'd1;
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, i, cyc, act, want);
    end
  endtask

  task automatic push(input int i, input int c, input logic w, input logic e, input logic d,
                      input logic r, input logic crx, input logic [31:0] v);
    exp_t x;
    x.cyc = c; x.w = w; x.e = e; x.dn = d; x.rdy = r; x.chk_rx = crx; x.rx = v;
    sb[i].push_back(x);
  endtask

  task automatic expect_idle(input int i, input int from, input int n);
    for (int k = 0; k < n; k++) push(i, from + k, 0, 0, 0, 1, 0, 0);
  endtask

  // expected per-cycle outputs for a word accepted in cycle c0, up to relative cycle tmax
  task automatic push_word(input int i, input logic [31:0] word, input int c0, input int tmax);
    int n, p;
    n = nw[i];
    p = dv[i];
    for (int t = 1; t <= n * p + 2 && t <= tmax; t++)
      if (t <= n * p) push(i, c0 + t, word[(t - 1) / p], (t % p) == 0, 0, 0, 0, 0);
      else if (t == n * p + 1) push(i, c0 + t, 0, 0, 1, 0, 1, word & mask(n));
      else push(i, c0 + t, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic send(input int i, input logic [31:0] word);
    int c0;
    chk("ready_before_start", i, 32'(rdy[i]), 32'd1);
    dd[i] = word;
    st[i] = 1;
    c0 = cyc;
    push_word(i, word, c0, 1 << 30);
    @(posedge clk); #1;
    st[i] = 0;
    dd[i] = ~word;
    repeat (nw[i] * dv[i] + 1) @(posedge clk);
    #1;
  endtask

  // monitor: pop every expectation due this cycle and compare against the DUT
  always @(negedge clk) begin
    exp_t x;
    for (int i = 0; i < 3; i++)
      while (sb[i].size() > 0 && sb[i][0].cyc <= cyc) begin
        x = sb[i].pop_front();
        chk("w", i, 32'(ww[i]), 32'(x.w));
        chk("e", i, 32'(ee[i]), 32'(x.e));
        chk("done", i, 32'(dn[i]), 32'(x.dn));
        chk("ready", i, 32'(rdy[i]), 32'(x.rdy));
        if (x.chk_rx) chk("rx_word", i, rx[i] & mask(nw[i]), x.rx);
      end
  end

  initial begin
    int c0, left;
    for (int i = 0; i < 3; i++) begin
      rstn[i] = 0; st[i] = 0; dd[i] = 0; rx[i] = 0;
    end
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 3; i++) expect_idle(i, cyc, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) rstn[i] = 1;
    for (int i = 0; i < 3; i++) expect_idle(i, cyc, 10);
    repeat (10) @(posedge clk); #1;
    send(0, 32'hA5);
    send(0, 32'h00);
    send(0, 32'hFF);
    send(1, 32'h8000_0001);
    // start held high: second acceptance lands at cycle 10 with the new d
    chk("ready_before_hold", 0, 32'(rdy[0]), 32'd1);
    dd[0] = 32'h3C;
    st[0] = 1;
    c0 = cyc;
    push_word(0, 32'h3C, c0, 1 << 30);
    push_word(0, 32'hC3, c0 + 10, 1 << 30);
    @(posedge clk); #1;
    dd[0] = 32'hC3;
    repeat (10) @(posedge clk); #1;
    st[0] = 0;
    dd[0] = 32'h00;
    repeat (9) @(posedge clk); #1;
    expect_idle(0, cyc, 5);
    repeat (5) @(posedge clk); #1;
    // abort mid-word with an asynchronous reset in cycle 7
    dd[2] = 32'h5A;
    st[2] = 1;
    c0 = cyc;
    push_word(2, 32'h5A, c0, 6);
    @(posedge clk); #1;
    st[2] = 0;
    repeat (6) @(posedge clk);
    #2;
    rstn[2] = 0;
    expect_idle(2, cyc, 3);
    repeat (3) @(posedge clk); #1;
    rstn[2] = 1;
    expect_idle(2, cyc, 2);
    repeat (2) @(posedge clk); #1;
    send(2, 32'h96);
    left = 1;
    for (int k = 0; k < 200 && left > 0; k++) begin
      @(posedge clk); #1;
      left = sb[0].size() + sb[1].size() + sb[2].size();
    end
    if (left > 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", left);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
